// File: rtl/conv3x3_window_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv_pkg
// Purpose  : Shared types and window-index constants for the 3x3 feeder.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } feeder_state_t;

   localparam int WIN_ROWS = 3;
   localparam int WIN_COLS = 3;
   localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;

   // Row slots inside the window: oldest line first, current line last.
   localparam int WIN_ROW_TOP = 0;
   localparam int WIN_ROW_MID = 1;
   localparam int WIN_ROW_CUR = 2;

   function automatic int win_idx(input int row, input int col);
      return row * WIN_COLS + col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_window_feeder_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Purpose  : One image row of delay; combinational read-before-write by column.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Storage is deliberately left unreset; stale rows are never emitted.
   logic unused_arst_n;
   assign unused_arst_n = arst_n_in;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
   end

   assign dout = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/conv3x3_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_window_feeder
// Purpose  : Raster pixel stream to registered 3x3 valid-convolution windows.
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_window_feeder
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input  logic                  clk,
   input  logic                  arst_n_in,
   input  logic                  start,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic                  win_valid,
   output logic [DATA_WIDTH-1:0] win0,
   output logic [DATA_WIDTH-1:0] win1,
   output logic [DATA_WIDTH-1:0] win2,
   output logic [DATA_WIDTH-1:0] win3,
   output logic [DATA_WIDTH-1:0] win4,
   output logic [DATA_WIDTH-1:0] win5,
   output logic [DATA_WIDTH-1:0] win6,
   output logic [DATA_WIDTH-1:0] win7,
   output logic [DATA_WIDTH-1:0] win8,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
   localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);
   localparam logic [RW-1:0] ROW_FILL_LAST = RW'(1);

   feeder_state_t         state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [DATA_WIDTH-1:0] shift_q [WIN_TAPS];
   logic [DATA_WIDTH-1:0] shift_d [WIN_TAPS];
   logic [DATA_WIDTH-1:0] win_q   [WIN_TAPS];
   logic                  win_valid_q, win_valid_d;
   logic                  frame_done_q, frame_done_d;
   logic                  accept, col_last, row_last, emit;
   logic [DATA_WIDTH-1:0] lb1_dout, lb0_dout;

   assign pix_ready = (state_q == FILL) || (state_q == STREAM);
   assign busy      = pix_ready;
   assign accept    = pix_valid && pix_ready;
   assign col_last  = (col_q == COL_LAST);
   assign row_last  = (row_q == ROW_LAST);
   assign emit      = accept && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);

   line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (CW)
   ) u_lb1 (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .we        (accept),
      .addr      (col_q),
      .din       (pix_data),
      .dout      (lb1_dout)
   );

   line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (CW)
   ) u_lb0 (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .we        (accept),
      .addr      (col_q),
      .din       (lb1_dout),
      .dout      (lb0_dout)
   );

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      frame_done_d = 1'b0;
      win_valid_d  = emit;
      case (state_q)
         IDLE: begin
            col_d = '0;
            row_d = '0;
            if (start) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (accept && col_last && (row_q == ROW_FILL_LAST)) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (accept && col_last && row_last) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // New column enters on the right; older columns slide towards index 0.
   always_comb begin
      shift_d = shift_q;
      for (int r = 0; r < WIN_ROWS; r++) begin
         shift_d[win_idx(r, 0)] = shift_q[win_idx(r, 1)];
         shift_d[win_idx(r, 1)] = shift_q[win_idx(r, 2)];
      end
      shift_d[win_idx(WIN_ROW_TOP, 2)] = lb0_dout;
      shift_d[win_idx(WIN_ROW_MID, 2)] = lb1_dout;
      shift_d[win_idx(WIN_ROW_CUR, 2)] = pix_data;
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < WIN_TAPS; i++) begin
            shift_q[i] <= '0;
            win_q[i]   <= '0;
         end
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         if (accept) begin
            shift_q <= shift_d;
         end
         if (emit) begin
            win_q <= shift_d;
         end
      end
   end

   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
   assign win0 = win_q[0];
   assign win1 = win_q[1];
   assign win2 = win_q[2];
   assign win3 = win_q[3];
   assign win4 = win_q[4];
   assign win5 = win_q[5];
   assign win6 = win_q[6];
   assign win7 = win_q[7];
   assign win8 = win_q[8];

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_window_feeder
// Purpose  : Scoreboard bench for the 3x3 window feeder on 4x4, 3x3, 32x32 frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_window_feeder;

   localparam int DW = 16;
   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          arst_n;
   logic          start_s [NI];
   logic          pv      [NI];
   logic          pr      [NI];
   logic          wv      [NI];
   logic          bz      [NI];
   logic          fd      [NI];
   logic [DW-1:0] pd      [NI];
   logic [DW-1:0] w       [NI][9];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : ((g == 1) ? 3 : 32);
      conv3x3_window_feeder #(
         .DATA_WIDTH (DW),
         .IMG_WIDTH  (D),
         .IMG_HEIGHT (D)
      ) u_dut (
         .clk        (clk),
         .arst_n_in  (arst_n),
         .start      (start_s[g]),
         .pix_valid  (pv[g]),
         .pix_ready  (pr[g]),
         .pix_data   (pd[g]),
         .win_valid  (wv[g]),
         .win0       (w[g][0]),
         .win1       (w[g][1]),
         .win2       (w[g][2]),
         .win3       (w[g][3]),
         .win4       (w[g][4]),
         .win5       (w[g][5]),
         .win6       (w[g][6]),
         .win7       (w[g][7]),
         .win8       (w[g][8]),
         .busy       (bz[g]),
         .frame_done (fd[g])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int nwin [NI];
   int nfd  [NI];

   logic [DW-1:0]   img [$];
   int              wq_inst [$];
   int              wq_cyc  [$];
   logic [9*DW-1:0] wq_win  [$];
   int              fq_inst [$];
   int              fq_cyc  [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input string detail);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   function automatic logic [9*DW-1:0] pack_dut(input int g);
      logic [9*DW-1:0] v;
      for (int k = 0; k < 9; k++) v[k*DW +: DW] = w[g][k];
      return v;
   endfunction

   // Window straight from the stored frame: rows r-2..r, cols c-2..c.
   function automatic logic [9*DW-1:0] ref_win(input int dim, input int r, input int c);
      logic [9*DW-1:0] v;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            v[(i*3+j)*DW +: DW] = img[(r-2+i)*dim + (c-2+j)];
      return v;
   endfunction

   always @(negedge clk) begin : monitor
      logic [9*DW-1:0] got, ew;
      int ei, ec;
      for (int g = 0; g < NI; g++) begin
         if (wv[g] === 1'b1) begin
            got = pack_dut(g);
            nwin[g]++;
            if (wq_win.size() == 0) begin
               check(1'b0, "win_unexpected", $sformatf("inst %0d cyc %0d got=%h required=none", g, cyc, got));
            end else begin
               ei = wq_inst.pop_front();
               ec = wq_cyc.pop_front();
               ew = wq_win.pop_front();
               check((ei == g) && (ec == cyc) && (ew === got), "window",
                     $sformatf("got inst %0d cyc %0d win=%h required inst %0d cyc %0d win=%h",
                               g, cyc, got, ei, ec, ew));
            end
         end
         if (fd[g] === 1'b1) begin
            nfd[g]++;
            if (fq_cyc.size() == 0) begin
               check(1'b0, "frame_done_unexpected", $sformatf("inst %0d cyc %0d", g, cyc));
            end else begin
               ei = fq_inst.pop_front();
               ec = fq_cyc.pop_front();
               check((ei == g) && (ec == cyc), "frame_done",
                     $sformatf("got inst %0d cyc %0d required inst %0d cyc %0d", g, cyc, ei, ec));
            end
         end
      end
   end

   task automatic do_start(input int g);
      start_s[g] = 1'b1;
      @(posedge clk); #1;
      start_s[g] = 1'b0;
   endtask

   // start_mode: 0 none, 1 start alongside the last pixel, 2 start in the frame_done cycle
   task automatic send_frame(input int g, input int dim, input bit gaps,
                             input int mid_start, input int start_mode, input int stop_after);
      int n_total, limit, r, c, wc;
      n_total = dim * dim;
      limit   = (stop_after >= 0) ? stop_after : n_total;
      for (int n = 0; n < limit; n++) begin
         if (gaps && n > 0) begin
            pv[g] = 1'b0;
            @(negedge clk);
            check(pr[g] === 1'b1, "ready_in_gap", $sformatf("inst %0d pix %0d got=%b required=1", g, n, pr[g]));
            @(posedge clk); #1;
         end
         pv[g]      = 1'b1;
         pd[g]      = img[n];
         start_s[g] = (n == mid_start) || (start_mode == 1 && n == n_total - 1);
         @(negedge clk);
         wc = 0;
         while (pr[g] !== 1'b1 && wc < 20) begin
            @(negedge clk);
            wc++;
         end
         if (pr[g] !== 1'b1) begin
            check(1'b0, "ready_timeout", $sformatf("inst %0d pix %0d got=%b required=1", g, n, pr[g]));
            break;
         end
         r = n / dim;
         c = n % dim;
         if (r >= 2 && c >= 2) begin
            wq_inst.push_back(g);
            wq_cyc.push_back(cyc + 1);
            wq_win.push_back(ref_win(dim, r, c));
         end
         if (n == n_total - 1) begin
            fq_inst.push_back(g);
            fq_cyc.push_back(cyc + 1);
         end
         @(posedge clk); #1;
         start_s[g] = 1'b0;
      end
      pv[g] = 1'b0;
      if (start_mode == 2) do_start(g);
   endtask

   task automatic drain(input string name);
      repeat (6) @(posedge clk);
      #1;
      check(wq_win.size() == 0, {name, "_windows_left"}, $sformatf("got=%0d required=0", wq_win.size()));
      check(fq_cyc.size() == 0, {name, "_frame_done_left"}, $sformatf("got=%0d required=0", fq_cyc.size()));
   endtask

   task automatic fill_seq(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(DW'(i));
   endtask

   task automatic fill_rand(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(DW'($urandom));
   endtask

   task automatic check_zero(input int g, input string name);
      check(pr[g] === 1'b0 && wv[g] === 1'b0 && bz[g] === 1'b0 && fd[g] === 1'b0 && pack_dut(g) === '0,
            name, $sformatf("inst %0d got rdy=%b wv=%b busy=%b fd=%b win=%h required all 0",
                            g, pr[g], wv[g], bz[g], fd[g], pack_dut(g)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      arst_n = 1'b0;
      for (int g = 0; g < NI; g++) begin
         start_s[g] = 1'b0;
         pv[g]      = 1'b0;
         pd[g]      = '0;
         nwin[g]    = 0;
         nfd[g]     = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NI; g++) check_zero(g, "reset_state");
      arst_n = 1'b1;
      @(posedge clk); #1;

      // 4x4 back-to-back, pixels 0..15
      fill_seq(16);
      do_start(0);
      send_frame(0, 4, 1'b0, -1, 0, -1);
      drain("basic");
      check(nwin[0] == 4, "basic_count", $sformatf("got=%0d required=4", nwin[0]));

      // same frame with one idle cycle between pixels
      do_start(0);
      send_frame(0, 4, 1'b1, -1, 0, -1);
      drain("gaps");
      check(nwin[0] == 8, "gaps_count", $sformatf("got=%0d required=8", nwin[0]));

      // 3x3 frame of -1..-9
      img.delete();
      for (int i = 1; i <= 9; i++) img.push_back(DW'(-i));
      do_start(1);
      send_frame(1, 3, 1'b0, -1, 0, -1);
      drain("negative");
      check(nwin[1] == 1, "negative_count", $sformatf("got=%0d required=1", nwin[1]));
      check(w[1][0] === 16'hFFFF && w[1][8] === 16'hFFF7, "negative_bits",
            $sformatf("got win0=%h win8=%h required FFFF FFF7", w[1][0], w[1][8]));

      // start mid-frame ignored, start in frame_done cycle begins frame 2
      fill_rand(16);
      do_start(0);
      send_frame(0, 4, 1'b0, 6, 2, -1);
      fill_rand(16);
      send_frame(0, 4, 1'b0, -1, 1, -1);
      drain("busy_start");
      @(negedge clk);
      check(bz[0] === 1'b0 && pr[0] === 1'b0, "start_with_last_ignored",
            $sformatf("got busy=%b rdy=%b required 0 0", bz[0], pr[0]));
      check(nwin[0] == 16, "busy_start_count", $sformatf("got=%0d required=16", nwin[0]));
      @(posedge clk); #1;

      // asynchronous reset after 7 pixels, then a clean frame
      fill_rand(16);
      do_start(0);
      send_frame(0, 4, 1'b0, -1, 0, 7);
      #2;
      arst_n = 1'b0;
      #1;
      check_zero(0, "abort_outputs");
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check(bz[0] === 1'b0, "abort_needs_start", $sformatf("got busy=%b required 0", bz[0]));
      @(posedge clk); #1;
      base = nwin[0];
      fill_rand(16);
      do_start(0);
      send_frame(0, 4, 1'b0, -1, 0, -1);
      drain("abort");
      check(nwin[0] - base == 4, "abort_count", $sformatf("got=%0d required=4", nwin[0] - base));

      // full 32x32 random frame
      fill_rand(1024);
      do_start(2);
      send_frame(2, 32, 1'b0, -1, 0, -1);
      drain("full");
      check(nwin[2] == 900, "full_count", $sformatf("got=%0d required=900", nwin[2]));
      check(nfd[2] == 1, "full_frame_done", $sformatf("got=%0d required=1", nfd[2]));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
